// File: rtl/instr_aligner.sv
// Realigns a 32-bit fetch stream into 16/32-bit instructions via a 3-halfword queue; output is
// combinational from the queue (0-cycle), fetch stalls while 2+ halfwords are held, output holds under ins_ready_i=0.
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_data_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_comp_o
);

    logic [15:0] r_q [3];
    logic [1:0]  r_cnt;
    logic [31:0] r_pc;
    logic        r_skip;

    logic        w_is32;
    logic        w_complete;
    logic        w_pop_fire;
    logic        w_push_fire;
    logic [1:0]  w_pop_n;
    logic [1:0]  w_push_n;
    logic [1:0]  w_rem;
    logic [15:0] w_shift [3];
    logic [15:0] w_nq [3];

    assign w_is32      = (r_q[0][1:0] == 2'b11);
    assign w_complete  = w_is32 ? (r_cnt >= 2'd2) : (r_cnt != 2'd0);

    assign ins_valid_o   = w_complete & ~flush_i;
    assign fetch_ready_o = (r_cnt <= 2'd1) & ~flush_i;
    assign ins_comp_o    = w_complete & ~w_is32;
    assign ins_pc_o      = r_pc;
    assign ins_o         = !w_complete ? 32'h0 :
                           (w_is32 ? {r_q[1], r_q[0]} : {16'h0000, r_q[0]});

    assign w_pop_fire  = ins_valid_o & ins_ready_i;
    assign w_push_fire = fetch_valid_i & fetch_ready_o;
    assign w_pop_n     = !w_pop_fire  ? 2'd0 : (w_is32 ? 2'd2 : 2'd1);
    assign w_push_n    = !w_push_fire ? 2'd0 : (r_skip ? 2'd1 : 2'd2);
    assign w_rem       = r_cnt - w_pop_n;

    // Pop shifts the queue down first; pushed halfwords land right behind the survivors.
    always_comb begin
        w_shift[0] = r_q[0];
        w_shift[1] = r_q[1];
        w_shift[2] = r_q[2];
        if (w_pop_n == 2'd1) begin
            w_shift[0] = r_q[1];
            w_shift[1] = r_q[2];
        end else if (w_pop_n == 2'd2) begin
            w_shift[0] = r_q[2];
        end

        for (int i = 0; i < 3; i++) begin
            w_nq[i] = w_shift[i];
            if (w_push_fire) begin
                if (r_skip) begin
                    if (2'(i) == w_rem) w_nq[i] = fetch_data_i[31:16];
                end else begin
                    if (2'(i) == w_rem)        w_nq[i] = fetch_data_i[15:0];
                    if (2'(i) == w_rem + 2'd1) w_nq[i] = fetch_data_i[31:16];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_pc   <= RESET_PC & 32'hFFFF_FFFE;
            r_skip <= RESET_PC[1];
            for (int i = 0; i < 3; i++) r_q[i] <= 16'h0;
        end else if (flush_i) begin
            r_cnt  <= 2'd0;
            r_pc   <= redirect_pc_i & 32'hFFFF_FFFE;
            r_skip <= redirect_pc_i[1];
        end else begin
            for (int i = 0; i < 3; i++) r_q[i] <= w_nq[i];
            r_cnt <= w_rem + w_push_n;
            r_pc  <= r_pc + {29'h0, w_pop_n, 1'b0};
            if (w_push_fire) r_skip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: queue-based reference model checked every cycle, plus literal scenarios.
module tb_instr_aligner;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i;
    logic        ins_valid_o;
    logic        ins_ready_i;
    logic [31:0] ins_o;
    logic [31:0] ins_pc_o;
    logic        ins_comp_o;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [15:0] mq[$];
    logic [31:0] mpc;
    bit          mskip;

    instr_aligner #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_data_i  (fetch_data_i),
        .ins_valid_o   (ins_valid_o),
        .ins_ready_i   (ins_ready_i),
        .ins_o         (ins_o),
        .ins_pc_o      (ins_pc_o),
        .ins_comp_o    (ins_comp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Length in halfwords of the instruction at the queue head (0 if not yet complete).
    function automatic int m_len();
        logic [15:0] h;
        if (mq.size() == 0) return 0;
        h = mq[0];
        if (h[1:0] != 2'b11) return 1;
        return (mq.size() >= 2) ? 2 : 0;
    endfunction

    task automatic model_step();
        int n;
        bit take;
        if (!rst_n) begin
            mq.delete();
            mpc   = RST_PC & 32'hFFFF_FFFE;
            mskip = (RST_PC & 32'h2) != 0;
        end else if (flush_i) begin
            mq.delete();
            mpc   = redirect_pc_i & 32'hFFFF_FFFE;
            mskip = redirect_pc_i[1];
        end else begin
            n    = m_len();
            take = (mq.size() <= 1) && fetch_valid_i;
            if (n != 0 && ins_ready_i) begin
                repeat (n) void'(mq.pop_front());
                mpc = mpc + 32'(2 * n);
            end
            if (take) begin
                if (!mskip) mq.push_back(fetch_data_i[15:0]);
                mq.push_back(fetch_data_i[31:16]);
                mskip = 1'b0;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            int          n;
            logic [15:0] h0;
            n = m_len();
            chk("fetch_ready", {31'h0, fetch_ready_o}, {31'h0, (mq.size() <= 1) && !flush_i});
            chk("ins_valid", {31'h0, ins_valid_o}, {31'h0, (n != 0) && !flush_i});
            chk("ins_pc", ins_pc_o, mpc);
            if (n != 0 && !flush_i) begin
                h0 = mq[0];
                if (n == 2) begin
                    chk("ins_data32", ins_o, {mq[1], h0});
                    chk("ins_comp32", {31'h0, ins_comp_o}, 32'h0);
                end else begin
                    chk("ins_data16", ins_o, {16'h0, h0});
                    chk("ins_comp16", {31'h0, ins_comp_o}, 32'h1);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        nxt();
        fetch_valid_i = 1'b1;
        fetch_data_i  = w;
        nxt();
        fetch_valid_i = 1'b0;
    endtask

    task automatic pop1();
        nxt();
        ins_ready_i = 1'b1;
        nxt();
        ins_ready_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        nxt();
        flush_i       = 1'b1;
        redirect_pc_i = pc;
        nxt();
        flush_i = 1'b0;
    endtask

    task automatic lit(input string name, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic comp);
        chk({name, "_valid"}, {31'h0, ins_valid_o}, {31'h0, v});
        chk({name, "_pc"}, ins_pc_o, pc);
        if (v) begin
            chk({name, "_ins"}, ins_o, ins);
            chk({name, "_comp"}, {31'h0, ins_comp_o}, {31'h0, comp});
        end
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
        fetch_valid_i = 1'b0; fetch_data_i = '0; ins_ready_i = 1'b0;
        nxt();
        chk_en = 1'b1;
        nxt();
        mid();
        chk("rst_ins", ins_o, 32'h0);
        chk("rst_comp", {31'h0, ins_comp_o}, 32'h0);
        chk("rst_ready", {31'h0, fetch_ready_o}, 32'h1);
        lit("rst", 1'b0, 32'h0, 32'h0, 1'b0);

        // Two compressed instructions in one word.
        nxt();
        rst_n = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h4505_4501;
        nxt();
        fetch_valid_i = 1'b0;
        mid(); lit("two_a", 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        pop1();
        mid(); lit("two_b", 1'b1, 32'h0000_4505, 32'h2, 1'b1);
        pop1();
        mid(); lit("two_end", 1'b0, 32'h0, 32'h4, 1'b0);

        // 32-bit instruction straddling two words.
        redirect(32'h0);
        push(32'h0093_4501);
        mid(); lit("strad_a", 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        pop1();
        mid(); lit("strad_wait", 1'b0, 32'h0, 32'h2, 1'b0);
        push(32'h0000_0010);
        mid(); lit("strad_b", 1'b1, 32'h0010_0093, 32'h2, 1'b0);
        pop1();
        mid(); lit("strad_c", 1'b1, 32'h0000_0000, 32'h6, 1'b1);
        pop1();

        // Redirect to a halfword-aligned PC: lower halfword of the next word is dropped.
        nxt();
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        mid();
        chk("flush_ready", {31'h0, fetch_ready_o}, 32'h0);
        nxt();
        flush_i = 1'b0;
        push(32'h4585_FFFF);
        mid(); lit("misal", 1'b1, 32'h0000_4585, 32'h102, 1'b1);
        pop1();
        mid(); lit("misal_end", 1'b0, 32'h0, 32'h104, 1'b0);

        // Flush while holding the first half of a 32-bit instruction.
        redirect(32'h0);
        push(32'h0093_4501);
        pop1();
        mid(); lit("fl32_hold", 1'b0, 32'h0, 32'h2, 1'b0);
        redirect(32'h200);
        mid(); lit("fl32_after", 1'b0, 32'h0, 32'h200, 1'b0);
        push(32'h0000_0513);
        mid(); lit("fl32_new", 1'b1, 32'h0000_0513, 32'h200, 1'b0);
        pop1();

        // Backpressure with a full queue, then ordered drain.
        redirect(32'h0);
        push(32'h4505_4501);
        pop1();
        push(32'h0000_0093);
        nxt();
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h4601_4611;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("bp_ready", {31'h0, fetch_ready_o}, 32'h0);
            lit("bp_hold", 1'b1, 32'h0000_4505, 32'h2, 1'b1);
            nxt();
        end
        ins_ready_i = 1'b1;
        nxt();
        mid(); lit("bp_d1", 1'b1, 32'h0000_0093, 32'h4, 1'b0);
        nxt();
        mid();
        chk("bp_empty_ready", {31'h0, fetch_ready_o}, 32'h1);
        lit("bp_empty", 1'b0, 32'h0, 32'h8, 1'b0);
        nxt();
        fetch_valid_i = 1'b0;
        mid(); lit("bp_d2", 1'b1, 32'h0000_4611, 32'h8, 1'b1);
        nxt();
        mid(); lit("bp_d3", 1'b1, 32'h0000_4601, 32'hA, 1'b1);
        nxt();
        ins_ready_i = 1'b0;

        // Reset in the middle of a stream.
        redirect(32'h40);
        push(32'h4505_4501);
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        mid(); lit("rst_mid", 1'b0, 32'h0, RST_PC, 1'b0);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst_n         = ($urandom_range(0, 199) != 0);
            flush_i       = ($urandom_range(0, 24) == 0);
            redirect_pc_i = $urandom;
            fetch_valid_i = ($urandom_range(0, 3) != 0);
            fetch_data_i  = $urandom;
            ins_ready_i   = ($urandom_range(0, 2) != 0);
        end
        nxt();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
